// File: rtl/bios_port_arbiter.sv
// Shares a single-port, synchronous-read BIOS between instruction fetch and data load,
// tagging each read with its owner and steering the 1-cycle-latency data back to it.
module bios_port_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              bios_en,
  output logic [ADDR_W-1:0] bios_addr,
  input  logic [DATA_W-1:0] bios_dout,
  output logic              stall_if,
  output logic              stall_ld
);

  // One spare code so the counter still has a bit when MAX_WAIT is 0.
  localparam int CNT_W = $clog2(MAX_WAIT + 2);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LD   = 2'd2
  } owner_e;

  owner_e            owner_r;
  owner_e            owner_nxt_s;
  logic [CNT_W-1:0]  starve_cnt_r;
  logic [CNT_W-1:0]  starve_cnt_nxt_s;
  logic [DATA_W-1:0] if_hold_r;
  logic [DATA_W-1:0] ld_hold_r;
  logic              if_gnt_s;
  logic              ld_gnt_s;
  logic              if_rvalid_s;
  logic              ld_rvalid_s;

  // Grant decision: LD preferred unless IF has waited MAX_WAIT cycles.
  always_comb begin
    if_gnt_s = 1'b0;
    ld_gnt_s = 1'b0;
    if (!rst_n) begin
      if_gnt_s = 1'b0;
      ld_gnt_s = 1'b0;
    end else if (if_req && ld_req) begin
      if (starve_cnt_r == MAX_CNT) begin
        if_gnt_s = 1'b1;
      end else begin
        ld_gnt_s = 1'b1;
      end
    end else if (if_req) begin
      if_gnt_s = 1'b1;
    end else if (ld_req) begin
      ld_gnt_s = 1'b1;
    end else begin
      if_gnt_s = 1'b0;
      ld_gnt_s = 1'b0;
    end
  end

  // Next owner tag and saturating IF starvation count.
  always_comb begin
    owner_nxt_s      = OWN_NONE;
    starve_cnt_nxt_s = {CNT_W{1'b0}};
    case ({if_gnt_s, ld_gnt_s})
      2'b10:   owner_nxt_s = OWN_IF;
      2'b01:   owner_nxt_s = OWN_LD;
      default: owner_nxt_s = OWN_NONE;
    endcase
    if (if_req && !if_gnt_s) begin
      if (starve_cnt_r == MAX_CNT) begin
        starve_cnt_nxt_s = starve_cnt_r;
      end else begin
        starve_cnt_nxt_s = starve_cnt_r + CNT_W'(1);
      end
    end else begin
      starve_cnt_nxt_s = {CNT_W{1'b0}};
    end
  end

  // State registers; hold registers capture the data of the owning side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_r      <= OWN_NONE;
      starve_cnt_r <= {CNT_W{1'b0}};
      if_hold_r    <= {DATA_W{1'b0}};
      ld_hold_r    <= {DATA_W{1'b0}};
    end else begin
      owner_r      <= owner_nxt_s;
      starve_cnt_r <= starve_cnt_nxt_s;
      if (if_rvalid_s) begin
        if_hold_r <= bios_dout;
      end
      if (ld_rvalid_s) begin
        ld_hold_r <= bios_dout;
      end
    end
  end

  assign if_rvalid_s = rst_n && (owner_r == OWN_IF);
  assign ld_rvalid_s = rst_n && (owner_r == OWN_LD);

  assign if_gnt    = if_gnt_s;
  assign ld_gnt    = ld_gnt_s;
  assign bios_en   = if_gnt_s | ld_gnt_s;
  assign bios_addr = !rst_n   ? {ADDR_W{1'b0}} :
                     ld_gnt_s ? ld_addr : if_addr;
  assign if_rvalid = if_rvalid_s;
  assign ld_rvalid = ld_rvalid_s;
  assign if_rdata  = !rst_n      ? {DATA_W{1'b0}} :
                     if_rvalid_s ? bios_dout : if_hold_r;
  assign ld_rdata  = !rst_n      ? {DATA_W{1'b0}} :
                     ld_rvalid_s ? bios_dout : ld_hold_r;
  assign stall_if  = rst_n & if_req & ~if_gnt_s;
  assign stall_ld  = rst_n & ld_req & ~ld_gnt_s;

endmodule

// File: tb/tb_bios_port_arbiter.sv
// Bench for bios_port_arbiter: two instances (MAX_WAIT=4 and MAX_WAIT=0) share stimulus;
// a cycle model checks every output each cycle, directed literals pin the scenarios.
module tb_bios_port_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          if_req  = 1'b0;
  logic          ld_req  = 1'b0;
  logic [AW-1:0] if_addr = 12'h000;
  logic [AW-1:0] ld_addr = 12'h000;

  logic          o_if_gnt    [2];
  logic          o_ld_gnt    [2];
  logic          o_if_rvalid [2];
  logic          o_ld_rvalid [2];
  logic          o_bios_en   [2];
  logic          o_stall_if  [2];
  logic          o_stall_ld  [2];
  logic [AW-1:0] o_bios_addr [2];
  logic [DW-1:0] o_if_rdata  [2];
  logic [DW-1:0] o_ld_rdata  [2];
  logic [DW-1:0] dout        [2];

  logic [DW-1:0] mem [0:4095];

  int checks   = 0;
  int failures = 0;

  // Model state: consecutive IF denials, owner of the in-flight read (0 none, 1 IF, 2 LD),
  // its address, and the last data delivered to each side.
  int            m_wait [2] = '{0, 0};
  int            m_own  [2] = '{0, 0};
  int            m_addr [2] = '{0, 0};
  logic [DW-1:0] m_hold_if [2] = '{32'h0, 32'h0};
  logic [DW-1:0] m_hold_ld [2] = '{32'h0, 32'h0};

  always #5 clk = ~clk;

  bios_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(o_if_gnt[0]),
    .if_rvalid(o_if_rvalid[0]), .if_rdata(o_if_rdata[0]),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(o_ld_gnt[0]),
    .ld_rvalid(o_ld_rvalid[0]), .ld_rdata(o_ld_rdata[0]),
    .bios_en(o_bios_en[0]), .bios_addr(o_bios_addr[0]), .bios_dout(dout[0]),
    .stall_if(o_stall_if[0]), .stall_ld(o_stall_ld[0])
  );

  bios_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(0)) dut_z (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(o_if_gnt[1]),
    .if_rvalid(o_if_rvalid[1]), .if_rdata(o_if_rdata[1]),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(o_ld_gnt[1]),
    .ld_rvalid(o_ld_rvalid[1]), .ld_rdata(o_ld_rdata[1]),
    .bios_en(o_bios_en[1]), .bios_addr(o_bios_addr[1]), .bios_dout(dout[1]),
    .stall_if(o_stall_if[1]), .stall_ld(o_stall_ld[1])
  );

  // Synchronous-read BIOS memories, one per instance.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (o_bios_en[k]) dout[k] <= mem[o_bios_addr[k]];
    end
  end

  task automatic check(input int k, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[dut%0d] t=%0t: actual=%h required=%h", name, k, $time, act, exp);
    end
  endtask

  function automatic int max_wait_of(input int k);
    return (k == 0) ? 4 : 0;
  endfunction

  function automatic logic mdl_if_gnt(input int k);
    return rst_n && if_req && (!ld_req || (m_wait[k] == max_wait_of(k)));
  endfunction

  function automatic logic mdl_ld_gnt(input int k);
    return rst_n && ld_req && !mdl_if_gnt(k);
  endfunction

  // Advance the model once per cycle.
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_wait[k]    <= 0;
        m_own[k]     <= 0;
        m_addr[k]    <= 0;
        m_hold_if[k] <= 32'h0;
        m_hold_ld[k] <= 32'h0;
      end else begin
        m_own[k]  <= mdl_if_gnt(k) ? 1 : (mdl_ld_gnt(k) ? 2 : 0);
        m_addr[k] <= mdl_ld_gnt(k) ? int'(ld_addr) : int'(if_addr);
        if (m_own[k] == 1) m_hold_if[k] <= mem[m_addr[k]];
        if (m_own[k] == 2) m_hold_ld[k] <= mem[m_addr[k]];
        if (if_req && !mdl_if_gnt(k))
          m_wait[k] <= (m_wait[k] < max_wait_of(k)) ? m_wait[k] + 1 : max_wait_of(k);
        else
          m_wait[k] <= 0;
      end
    end
  end

  // Compare every output of both instances against the model, away from the active edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic          e_if, e_ld, e_rv_if, e_rv_ld;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_rd_if, e_rd_ld;
      e_if    = mdl_if_gnt(k);
      e_ld    = mdl_ld_gnt(k);
      e_rv_if = rst_n && (m_own[k] == 1);
      e_rv_ld = rst_n && (m_own[k] == 2);
      e_addr  = !rst_n ? 12'h000 : (e_ld ? ld_addr : if_addr);
      e_rd_if = !rst_n ? 32'h0 : (e_rv_if ? mem[m_addr[k]] : m_hold_if[k]);
      e_rd_ld = !rst_n ? 32'h0 : (e_rv_ld ? mem[m_addr[k]] : m_hold_ld[k]);
      check(k, "if_gnt",    32'(o_if_gnt[k]),    32'(e_if));
      check(k, "ld_gnt",    32'(o_ld_gnt[k]),    32'(e_ld));
      check(k, "bios_en",   32'(o_bios_en[k]),   32'(e_if | e_ld));
      check(k, "bios_addr", 32'(o_bios_addr[k]), 32'(e_addr));
      check(k, "if_rvalid", 32'(o_if_rvalid[k]), 32'(e_rv_if));
      check(k, "ld_rvalid", 32'(o_ld_rvalid[k]), 32'(e_rv_ld));
      check(k, "if_rdata",  o_if_rdata[k],       e_rd_if);
      check(k, "ld_rdata",  o_ld_rdata[k],       e_rd_ld);
      check(k, "stall_if",  32'(o_stall_if[k]),  32'(rst_n && if_req && !e_if));
      check(k, "stall_ld",  32'(o_stall_ld[k]),  32'(rst_n && ld_req && !e_ld));
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h5A00_0000 | 32'(i);
    mem[12'h010] = 32'hDEADBEEF;
    mem[12'h001] = 32'h11111111;
    mem[12'h002] = 32'h22222222;
    mem[12'h020] = 32'hCAFEF00D;
    mem[12'h0FF] = 32'h0BADF00D;

    repeat (3) next_cycle();
    check(0, "rst_bios_en", 32'(o_bios_en[0]), 32'h0);
    check(0, "rst_if_rdata", o_if_rdata[0], 32'h0);
    rst_n = 1'b1;

    // IF alone at 0x010
    if_req = 1'b1; if_addr = 12'h010;
    #1;
    check(0, "t1_if_gnt",    32'(o_if_gnt[0]),    32'h1);
    check(0, "t1_bios_en",   32'(o_bios_en[0]),   32'h1);
    check(0, "t1_bios_addr", 32'(o_bios_addr[0]), 32'h010);
    check(0, "t1_stall_if",  32'(o_stall_if[0]),  32'h0);
    next_cycle();
    if_req = 1'b0;
    #1;
    check(0, "t1_if_rvalid", 32'(o_if_rvalid[0]), 32'h1);
    check(0, "t1_if_rdata",  o_if_rdata[0],       32'hDEADBEEF);
    next_cycle();
    #1;
    check(0, "t1_rvalid_low", 32'(o_if_rvalid[0]), 32'h0);
    check(0, "t1_rdata_hold", o_if_rdata[0],       32'hDEADBEEF);

    // Both requesting: LD x4 then IF on dut_a, IF always on dut_z
    if_req = 1'b1; if_addr = 12'h030; ld_req = 1'b1; ld_addr = 12'h040;
    for (int i = 0; i < 10; i++) begin
      #1;
      check(0, "t2_if_gnt",   32'(o_if_gnt[0]),   32'((i % 5) == 4));
      check(0, "t2_ld_gnt",   32'(o_ld_gnt[0]),   32'((i % 5) != 4));
      check(0, "t2_stall_if", 32'(o_stall_if[0]), 32'((i % 5) != 4));
      check(1, "t2_if_gnt",   32'(o_if_gnt[1]),   32'h1);
      check(1, "t2_stall_ld", 32'(o_stall_ld[1]), 32'h1);
      if (i > 0) check(0, "t2_if_rvalid", 32'(o_if_rvalid[0]), 32'(((i - 1) % 5) == 4));
      next_cycle();
    end

    // Alternating single-cycle IF(0x001) / LD(0x002)
    if_req = 1'b0; ld_req = 1'b0;
    next_cycle();
    for (int i = 0; i < 6; i++) begin
      if_req = ((i % 2) == 0); if_addr = 12'h001;
      ld_req = ((i % 2) == 1); ld_addr = 12'h002;
      #1;
      check(0, "t3_gnt", 32'({o_if_gnt[0], o_ld_gnt[0]}), ((i % 2) == 0) ? 32'h2 : 32'h1);
      next_cycle();
      #1;
      check(0, "t3_if_rvalid", 32'(o_if_rvalid[0]), 32'((i % 2) == 0));
      check(0, "t3_ld_rvalid", 32'(o_ld_rvalid[0]), 32'((i % 2) == 1));
      check(0, "t3_if_rdata", o_if_rdata[0], 32'h11111111);
      if (i > 0) check(0, "t3_ld_rdata", o_ld_rdata[0], 32'h22222222);
    end

    // Completed LD read of 0xCAFEF00D, then 10 idle cycles
    if_req = 1'b0; ld_req = 1'b1; ld_addr = 12'h020;
    next_cycle();
    ld_req = 1'b0;
    #1;
    check(0, "t5_ld_rvalid", 32'(o_ld_rvalid[0]), 32'h1);
    check(0, "t5_ld_rdata",  o_ld_rdata[0],       32'hCAFEF00D);
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      #1;
      check(0, "t5_idle_en",     32'(o_bios_en[0]), 32'h0);
      check(0, "t5_idle_rvalid", 32'({o_if_rvalid[0], o_ld_rvalid[0]}), 32'h0);
      check(0, "t5_idle_rdata",  o_ld_rdata[0], 32'hCAFEF00D);
    end

    // LD granted at 0x0FF, reset pulsed the next cycle
    ld_req = 1'b1; ld_addr = 12'h0FF;
    #1;
    check(0, "t4_ld_gnt",    32'(o_ld_gnt[0]),    32'h1);
    check(0, "t4_bios_addr", 32'(o_bios_addr[0]), 32'h0FF);
    next_cycle();
    rst_n = 1'b0; if_req = 1'b1; ld_req = 1'b1;
    #1;
    check(0, "t4_rst_gnts",   32'({o_if_gnt[0], o_ld_gnt[0], o_bios_en[0]}), 32'h0);
    check(0, "t4_rst_addr",   32'(o_bios_addr[0]), 32'h0);
    check(0, "t4_rst_rvalid", 32'({o_if_rvalid[0], o_ld_rvalid[0]}), 32'h0);
    check(0, "t4_rst_rdata",  o_ld_rdata[0] | o_if_rdata[0], 32'h0);
    check(0, "t4_rst_stall",  32'({o_stall_if[0], o_stall_ld[0]}), 32'h0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    #1;
    check(0, "t4_post_rvalid", 32'(o_ld_rvalid[0]), 32'h0);
    check(0, "t4_post_rdata",  o_ld_rdata[0],       32'h0);
    for (int i = 0; i < 5; i++) begin
      check(0, "t4_post_ld_gnt", 32'(o_ld_gnt[0]), 32'(i < 4));
      check(0, "t4_post_if_gnt", 32'(o_if_gnt[0]), 32'(i == 4));
      next_cycle();
      #1;
    end

    if_req = 1'b0; ld_req = 1'b0;
    repeat (3) next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
